tlc_phase_timer: RTL and testbench
==================================

# tlc_phase_timer

Phase timer that paces the traffic-light controller. It divides `clk` into a slow tick, counts per-phase durations (red, green, yellow), and issues a one-cycle `adv` pulse. The controller uses `adv` as its clock enable to step to its next light. A latched pedestrian request shortens the current green phase. The timer keeps its own one-hot copy of the light sequence (red → green → yellow → red), so it is the single source of phase timing for the intersection.

## Interface
- `PRESCALE`, default 4: `clk` cycles per tick; must be ≥1.
- `RED_TICKS`, default 3: red duration in ticks; must be ≥1.
- `GREEN_TICKS`, default 5: green duration in ticks; must be ≥1.
- `YELLOW_TICKS`, default 2: yellow duration in ticks; must be ≥1.
- `PED_CUT`, default 2: maximum remaining green ticks once a pedestrian request is pending; must satisfy 1 ≤ `PED_CUT` ≤ `GREEN_TICKS`.
- `CNT_W`, default 8: width of the remaining-ticks counter; must be ≥ clog2 of the largest duration.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable; when low, the prescaler and phase counter are frozen.
- `ped_req`  in  1  pedestrian request; level or pulse, sampled every cycle.
- `phase`  out  3  registered one-hot phase: 001 = red, 010 = green, 100 = yellow.
- `tick`  out  1  registered; high for one cycle after each prescaler wrap.
- `adv`  out  1  registered; high for one cycle, during the first cycle of a new phase.
- `remaining`  out  `CNT_W`  ticks left in the current phase, minus one.
- `ped_pending`  out  1  a request is latched and not yet served.
- `ped_ack`  out  1  one-cycle pulse when a request is served (on red entry).

## Operation
- Reset values: `phase` = 001, `remaining` = `RED_TICKS`−1, prescaler = 0, `tick` = `adv` = `ped_pending` = `ped_ack` = 0.
- Prescaler:
  - Counts 0..`PRESCALE`−1 on cycles where `en`=1.
  - A terminal count with `en`=1 is a tick event: the prescaler wraps to 0 and `tick` is set on the next cycle.
- Phase counter, on a tick event:
  - If `remaining` ≠ 0: decrement.
  - If `remaining` = 0: advance phase (red → green → yellow → red), load the next duration minus 1, and set `adv` on the next cycle.
- Green entry while a request is pending (or `ped_req`=1 that cycle): load min(`GREEN_TICKS`, `PED_CUT`)−1.
- Truncation:
  - Applies when `phase` = green, `ped_pending` = 1, and `remaining` > `PED_CUT`−1.
  - `remaining` loads `PED_CUT`−1 on the next edge, whether or not a tick occurs.
  - Truncation takes priority over decrement in the same cycle. It never causes an advance.
- Pedestrian latch:
  - `ped_req`=1 while `phase` ≠ red sets `ped_pending`.
  - `ped_req` during red is ignored.
- Red entry:
  - If `ped_pending`=1 or `ped_req`=1 that cycle, `ped_ack` pulses together with the new phase and `ped_pending` clears. Clear wins over set.
- `en` low does not block `ped_req` latching or truncation.
- Asynchronous reset mid-phase returns all state to the reset values immediately; the pending request is dropped.

## Timing
- A phase of D ticks lasts exactly D×`PRESCALE` enabled cycles.
- Full cycle = (`RED_TICKS`+`GREEN_TICKS`+`YELLOW_TICKS`)×`PRESCALE` enabled cycles.
- `phase`, `adv`, and the new `remaining` all change on the same edge. The controller's light therefore updates one edge after `phase`.
- First tick event occurs on the `PRESCALE`th enabled cycle after reset release.
- `PRESCALE`=1: a tick event occurs every enabled cycle and `tick` stays high continuously.

## Structure
- Shared package `tlc_pkg`: phase encodings RED=3'b001, GREEN=3'b010, YELLOW=3'b100, plus a next-phase function.
- The controller imports the same package so that both blocks agree on the encoding.
- One natural sub-module: `tlc_prescaler` (counter plus tick strobe with enable). The phase counter, pedestrian latch, and phase register stay in the top module.

## Test plan
Parameters for all scenarios: `PRESCALE`=4, `RED_TICKS`=3, `GREEN_TICKS`=5, `YELLOW_TICKS`=2, `PED_CUT`=2.
- Reset release with `en`=1 → `adv` high in cycle 12; `phase` 001→010; next advances at cycles 32 (→100) and 40 (→001). Period is 40 cycles.
- `en` low for 10 cycles mid-red → first `adv` delayed by exactly 10 cycles; `remaining` and the prescaler hold their values.
- `ped_req` pulse in green at `remaining`=3 → `remaining`=1 next cycle; green ends 2 ticks later; `ped_ack`=1 on the red-entry cycle; `ped_pending`→0.
- `ped_req` held through red only → `ped_pending` stays 0; next green lasts the full 5 ticks.
- `ped_req` in the same cycle as the yellow→red tick event → `ped_ack` pulses with red entry; `ped_pending` stays 0.
- `rst_n` asserted mid-yellow → immediately `phase`=001, `remaining`=2, `adv`=`tick`=`ped_ack`=0; timing restarts from scenario 1 after release.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared phase encoding for the traffic-light phase timer and its controller.
package tlc_pkg;

    localparam int unsigned PHASE_W = 3;

    typedef enum logic [PHASE_W-1:0] {
        PH_RED    = 3'b001,
        PH_GREEN  = 3'b010,
        PH_YELLOW = 3'b100
    } phase_e;

    // Light sequence: red -> green -> yellow -> red.
    function automatic phase_e next_phase(input phase_e p);
        phase_e n;
        case (p)
            PH_RED:    n = PH_GREEN;
            PH_GREEN:  n = PH_YELLOW;
            PH_YELLOW: n = PH_RED;
            default:   n = PH_RED;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/tlc_prescaler.sv
// Clock divider: counts enabled cycles and flags each wrap as a tick event.
module tlc_prescaler #(
    parameter int unsigned PRESCALE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic wrap_c,
    output logic tick_o
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] TERM = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] cnt_q, cnt_d;
    logic            tick_q;

    // Tick event on terminal count of an enabled cycle.
    assign wrap_c = en_i && (cnt_q == TERM);
    assign tick_o = tick_q;

    // Next count: hold when disabled, wrap to zero on a tick event.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = wrap_c ? '0 : cnt_q + PS_W'(1);
        end
    end

    // Counter and registered tick strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= wrap_c;
        end
    end

endmodule

// File: rtl/tlc_phase_timer.sv
// Phase timer: per-phase tick countdown, phase sequencing, pedestrian shortening of green.
module tlc_phase_timer
    import tlc_pkg::*;
#(
    parameter int unsigned PRESCALE     = 4,
    parameter int unsigned RED_TICKS    = 3,
    parameter int unsigned GREEN_TICKS  = 5,
    parameter int unsigned YELLOW_TICKS = 2,
    parameter int unsigned PED_CUT      = 2,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ped_req,
    output logic [2:0]       phase,
    output logic             tick,
    output logic             adv,
    output logic [CNT_W-1:0] remaining,
    output logic             ped_pending,
    output logic             ped_ack
);

    localparam int unsigned PED_GREEN = (GREEN_TICKS < PED_CUT) ? GREEN_TICKS : PED_CUT;

    localparam logic [CNT_W-1:0] RED_LD       = CNT_W'(RED_TICKS - 1);
    localparam logic [CNT_W-1:0] GREEN_LD     = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD    = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] PED_GREEN_LD = CNT_W'(PED_GREEN - 1);
    localparam logic [CNT_W-1:0] CUT_LD       = CNT_W'(PED_CUT - 1);

    phase_e           phase_q, phase_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             adv_q, adv_d;
    logic             ped_pending_q, ped_pending_d;
    logic             ped_ack_q, ped_ack_d;
    logic             wrap_c;
    logic             req_any_c;

    tlc_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (en),
        .wrap_c (wrap_c),
        .tick_o (tick)
    );

    // A request counts at a phase boundary if latched earlier or present this cycle.
    assign req_any_c = ped_pending_q || ped_req;

    // Next phase, countdown, pedestrian latch and strobes.
    always_comb begin
        phase_d       = phase_q;
        remaining_d   = remaining_q;
        ped_pending_d = ped_pending_q;
        adv_d         = 1'b0;
        ped_ack_d     = 1'b0;

        if (ped_req && (phase_q != PH_RED)) begin
            ped_pending_d = 1'b1;
        end

        // Truncation never coincides with remaining == 0, so it can never advance.
        if ((phase_q == PH_GREEN) && ped_pending_q && (remaining_q > CUT_LD)) begin
            remaining_d = CUT_LD;
        end else if (wrap_c) begin
            if (remaining_q != '0) begin
                remaining_d = remaining_q - CNT_W'(1);
            end else begin
                phase_d = next_phase(phase_q);
                adv_d   = 1'b1;
                case (phase_d)
                    PH_RED: begin
                        remaining_d = RED_LD;
                        if (req_any_c) begin
                            ped_ack_d     = 1'b1;
                            ped_pending_d = 1'b0;
                        end
                    end
                    PH_GREEN:  remaining_d = req_any_c ? PED_GREEN_LD : GREEN_LD;
                    PH_YELLOW: remaining_d = YELLOW_LD;
                    default:   remaining_d = RED_LD;
                endcase
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q       <= PH_RED;
            remaining_q   <= RED_LD;
            adv_q         <= 1'b0;
            ped_pending_q <= 1'b0;
            ped_ack_q     <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            remaining_q   <= remaining_d;
            adv_q         <= adv_d;
            ped_pending_q <= ped_pending_d;
            ped_ack_q     <= ped_ack_d;
        end
    end

    assign phase       = phase_q;
    assign remaining   = remaining_q;
    assign adv         = adv_q;
    assign ped_pending = ped_pending_q;
    assign ped_ack     = ped_ack_q;

endmodule

// File: tb/tb_tlc_phase_timer.sv
// Self-checking bench for tlc_phase_timer: directed scenarios plus random traffic vs. a reference model.
module tb_tlc_phase_timer;

    localparam int unsigned PRESCALE = 4;
    localparam int unsigned RED_T    = 3;
    localparam int unsigned GREEN_T  = 5;
    localparam int unsigned YELLOW_T = 2;
    localparam int unsigned PED_CUT  = 2;
    localparam int unsigned CNT_W    = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             ped_req;
    logic [2:0]       phase;
    logic             tick;
    logic             adv;
    logic [CNT_W-1:0] remaining;
    logic             ped_pending;
    logic             ped_ack;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: phase index 0=red,1=green,2=yellow.
    int m_idx;
    int m_rem;
    int m_pcnt;
    bit m_tick, m_adv, m_pend, m_ack;

    always #5 clk = ~clk;

    tlc_phase_timer #(
        .PRESCALE     (PRESCALE),
        .RED_TICKS    (RED_T),
        .GREEN_TICKS  (GREEN_T),
        .YELLOW_TICKS (YELLOW_T),
        .PED_CUT      (PED_CUT),
        .CNT_W        (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .ped_req     (ped_req),
        .phase       (phase),
        .tick        (tick),
        .adv         (adv),
        .remaining   (remaining),
        .ped_pending (ped_pending),
        .ped_ack     (ped_ack)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int dur_of(input int idx);
        case (idx)
            0:       return RED_T;
            1:       return GREEN_T;
            default: return YELLOW_T;
        endcase
    endfunction

    task automatic model_reset();
        m_idx  = 0;
        m_rem  = RED_T - 1;
        m_pcnt = 0;
        m_tick = 0;
        m_adv  = 0;
        m_pend = 0;
        m_ack  = 0;
    endtask

    // One clock edge of the reference behaviour, given the inputs applied before it.
    task automatic model_step(input bit e, input bit r);
        bit tev;
        int n_idx, n_rem, n_pcnt;
        bit n_pend, n_ack, n_adv;
        tev    = e && (m_pcnt == PRESCALE - 1);
        n_pcnt = e ? (tev ? 0 : m_pcnt + 1) : m_pcnt;
        n_idx  = m_idx;
        n_rem  = m_rem;
        n_pend = m_pend || (r && m_idx != 0);
        n_ack  = 0;
        n_adv  = 0;
        if (m_idx == 1 && m_pend && m_rem > PED_CUT - 1) begin
            n_rem = PED_CUT - 1;
        end else if (tev) begin
            if (m_rem > 0) begin
                n_rem = m_rem - 1;
            end else begin
                n_idx = (m_idx + 1) % 3;
                n_adv = 1;
                n_rem = dur_of(n_idx) - 1;
                if (n_idx == 1 && (m_pend || r))
                    n_rem = ((GREEN_T < PED_CUT) ? GREEN_T : PED_CUT) - 1;
                if (n_idx == 0 && (m_pend || r)) begin
                    n_ack  = 1;
                    n_pend = 0;
                end
            end
        end
        m_idx  = n_idx;
        m_rem  = n_rem;
        m_pcnt = n_pcnt;
        m_tick = tev;
        m_adv  = n_adv;
        m_pend = n_pend;
        m_ack  = n_ack;
    endtask

    task automatic check_all();
        check_eq("phase",     32'(phase),       32'(1 << m_idx));
        check_eq("remaining", 32'(remaining),   32'(m_rem));
        check_eq("tick",      32'(tick),        32'(m_tick));
        check_eq("adv",       32'(adv),         32'(m_adv));
        check_eq("pending",   32'(ped_pending), 32'(m_pend));
        check_eq("ack",       32'(ped_ack),     32'(m_ack));
    endtask

    task automatic cycle(input bit e, input bit r);
        en      = e;
        ped_req = r;
        @(posedge clk);
        model_step(e, r);
        #1;
        check_all();
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any edge, released just after an edge.
    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    // Reset release with en=1: advances after edges 12, 32, 40.
    task automatic run_s1(input string tag);
        for (int k = 1; k <= 40; k++) begin
            cycle(1'b1, 1'b0);
            if (k == 12) begin
                check_eq({tag, "_adv12"}, 32'(adv), 32'd1);
                check_eq({tag, "_ph12"}, 32'(phase), 32'b010);
            end
            if (k == 32) begin
                check_eq({tag, "_adv32"}, 32'(adv), 32'd1);
                check_eq({tag, "_ph32"}, 32'(phase), 32'b100);
            end
            if (k == 40) begin
                check_eq({tag, "_adv40"}, 32'(adv), 32'd1);
                check_eq({tag, "_ph40"}, 32'(phase), 32'b001);
            end
        end
    endtask

    task automatic run_until_phase(input string tag, input logic [2:0] want);
        int guard = 0;
        while (phase !== want && guard < 100) begin
            cycle(1'b1, 1'b0);
            guard++;
        end
        check_eq({tag, "_reach"}, 32'(phase), 32'(want));
    endtask

    initial begin
        int total;
        int glen;
        bit done;
        rst_n   = 1'b0;
        en      = 1'b0;
        ped_req = 1'b0;
        model_reset();
        #12;
        check_eq("rst_phase", 32'(phase), 32'b001);
        check_eq("rst_rem",   32'(remaining), 32'(RED_T - 1));
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Scenario 1: free-running sequence.
        run_s1("s1");

        // Scenario 2: en low for 10 cycles in red delays the first advance by 10.
        do_reset();
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0);
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0);
        check_eq("s2_hold_rem", 32'(remaining), 32'(RED_T - 2));
        total = 15;
        done  = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            cycle(1'b1, 1'b0);
            total++;
            if (adv) done = 1;
        end
        check_eq("s2_adv_cycle", 32'(total), 32'd22);

        // Scenario 3: pedestrian pulse in green at remaining=3 truncates green.
        do_reset();
        run_until_phase("s3g", 3'b010);
        for (int k = 0; k < 20 && remaining != 3; k++) cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        check_eq("s3_pend", 32'(ped_pending), 32'd1);
        cycle(1'b1, 1'b0);
        check_eq("s3_trunc", 32'(remaining), 32'(PED_CUT - 1));
        run_until_phase("s3r", 3'b001);
        check_eq("s3_ack",  32'(ped_ack), 32'd1);
        check_eq("s3_clr",  32'(ped_pending), 32'd0);

        // Scenario 4: request held through red only (dropped before the green-entry cycle).
        do_reset();
        for (int k = 0; k < 11; k++) cycle(1'b1, 1'b1);
        check_eq("s4_nopend", 32'(ped_pending), 32'd0);
        cycle(1'b1, 1'b0);
        check_eq("s4_green", 32'(phase), 32'b010);
        check_eq("s4_full",  32'(remaining), 32'(GREEN_T - 1));
        glen = 0;
        done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            cycle(1'b1, 1'b0);
            glen++;
            if (adv) done = 1;
        end
        check_eq("s4_glen", 32'(glen), 32'(GREEN_T * PRESCALE));

        // Scenario 5: request on the exact yellow->red tick event.
        do_reset();
        run_until_phase("s5y", 3'b100);
        for (int k = 0; k < 20 && !(m_idx == 2 && m_rem == 0 && m_pcnt == PRESCALE - 1); k++)
            cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        check_eq("s5_phase", 32'(phase), 32'b001);
        check_eq("s5_ack",   32'(ped_ack), 32'd1);
        check_eq("s5_pend",  32'(ped_pending), 32'd0);

        // Scenario 6: reset mid-yellow, then timing restarts.
        run_until_phase("s6y", 3'b100);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b0);
        do_reset();
        check_eq("s6_rem", 32'(remaining), 32'(RED_T - 1));
        run_s1("s6");

        // Random traffic: enable gaps, sparse requests, rare resets.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 9) != 0, $urandom_range(0, 19) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
